// File: rtl/zbt_arb_pkg.sv
// Shared types and constants for the two-port ZBT SRAM arbiter.
// Holds the FSM state encoding, the latched Wishbone request record and the ZBT control idle levels.
package zbt_arb_pkg;

  localparam int ZBT_AW = 18;
  localparam int ZBT_DW = 32;
  localparam int WB_DW  = 16;

  localparam logic       CEN_N_IDLE    = 1'b1;
  localparam logic       WE_N_IDLE     = 1'b1;
  localparam logic       OE_N_IDLE     = 1'b1;
  localparam logic       ADV_LD_N_IDLE = 1'b0;
  localparam logic [3:0] BW_N_IDLE     = 4'hF;

  typedef enum logic [2:0] {IDLE, TURN, CMD, PIPE, DATA, ACK} state_e;

  typedef struct packed {
    logic [19:1]      adr;
    logic [WB_DW-1:0] dat;
    logic [1:0]       sel;
    logic             we;
  } wb_req_t;

  // Byte-write strobes: only the addressed 16-bit half is enabled, and only for writes.
  function automatic logic [3:0] bw_n_f(input wb_req_t r);
    logic [3:0] bw;
    bw = BW_N_IDLE;
    if (r.we) begin
      if (r.adr[1]) bw[3:2] = ~r.sel;
      else          bw[1:0] = ~r.sel;
    end
    return bw;
  endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-requester arbiter, round-robin or fixed priority to port 0.
// last_q_o is the most recently granted port and stays valid for the whole access.
module arb2_rr #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o,
  output logic       last_q_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ((FIXED_PRIO != 0) || last_q) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i)                      last_q <= 1'b1;
    else if (update_i && |req_i)    last_q <= gnt_o[1];
  end

  assign last_q_o = last_q;

endmodule

// File: rtl/zbt_arbiter.sv
// Shares one pipelined NoBL ZBT SRAM between two 16-bit Wishbone masters.
// One access at a time: CMD, PIPE, DATA, ACK, with optional read-to-write turnaround.
module zbt_arbiter
  import zbt_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int RD_TURN    = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [19:1]       wb0_adr_i,
  input  logic [WB_DW-1:0]  wb0_dat_i,
  output logic [WB_DW-1:0]  wb0_dat_o,
  input  logic [1:0]        wb0_sel_i,
  input  logic              wb0_we_i,
  input  logic              wb0_cyc_i,
  input  logic              wb0_stb_i,
  output logic              wb0_ack_o,
  input  logic [19:1]       wb1_adr_i,
  input  logic [WB_DW-1:0]  wb1_dat_i,
  output logic [WB_DW-1:0]  wb1_dat_o,
  input  logic [1:0]        wb1_sel_i,
  input  logic              wb1_we_i,
  input  logic              wb1_cyc_i,
  input  logic              wb1_stb_i,
  output logic              wb1_ack_o,
  output logic [ZBT_AW-1:0] zbt_addr_o,
  output logic [ZBT_DW-1:0] zbt_dat_o,
  input  logic [ZBT_DW-1:0] zbt_dat_i,
  output logic              zbt_dat_oe_o,
  output logic [3:0]        zbt_bw_n_o,
  output logic              zbt_we_n_o,
  output logic              zbt_cen_n_o,
  output logic              zbt_adv_ld_n_o,
  output logic              zbt_oe_n_o
);

  localparam logic [1:0] TURN_LD = 2'(RD_TURN);

  state_e           state_q, state_d;
  wb_req_t          req0, req1, req_sel, rq_q;
  logic [1:0]       req, gnt;
  logic             act_q;
  logic             prev_rd_q, abort_q, abort_d;
  logic [1:0]       turn_q, turn_d;
  logic [WB_DW-1:0] dat0_q, dat1_q, rd_half;
  logic             gcyc, ack;

  assign req0 = '{adr: wb0_adr_i, dat: wb0_dat_i, sel: wb0_sel_i, we: wb0_we_i};
  assign req1 = '{adr: wb1_adr_i, dat: wb1_dat_i, sel: wb1_sel_i, we: wb1_we_i};

  assign req[0] = wb0_cyc_i & wb0_stb_i & ~wb0_ack_o;
  assign req[1] = wb1_cyc_i & wb1_stb_i & ~wb1_ack_o;

  // The arbiter's last-grant register doubles as the owner of the access in flight.
  arb2_rr #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .req_i    (req),
    .update_i (state_q == IDLE),
    .gnt_o    (gnt),
    .last_q_o (act_q)
  );

  assign req_sel = gnt[1] ? req1 : req0;
  assign gcyc    = act_q ? wb1_cyc_i : wb0_cyc_i;
  assign ack     = (state_q == ACK) & gcyc & ~abort_q;

  assign wb0_ack_o = ack & ~act_q;
  assign wb1_ack_o = ack &  act_q;
  assign wb0_dat_o = dat0_q;
  assign wb1_dat_o = dat1_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|gnt) state_d = (prev_rd_q && req_sel.we && turn_q != 2'd0) ? TURN : CMD;
      TURN: if (turn_q <= 2'd1) state_d = CMD;
      CMD:  state_d = PIPE;
      PIPE: state_d = DATA;
      DATA: state_d = ACK;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    zbt_cen_n_o    = CEN_N_IDLE;
    zbt_we_n_o     = WE_N_IDLE;
    zbt_oe_n_o     = OE_N_IDLE;
    zbt_bw_n_o     = BW_N_IDLE;
    zbt_adv_ld_n_o = ADV_LD_N_IDLE;
    zbt_dat_oe_o   = 1'b0;
    case (state_q)
      CMD: begin
        zbt_cen_n_o = 1'b0;
        zbt_we_n_o  = ~rq_q.we;
        zbt_bw_n_o  = bw_n_f(rq_q);
      end
      PIPE: zbt_oe_n_o = rq_q.we;
      DATA: begin
        zbt_oe_n_o   = rq_q.we;
        zbt_dat_oe_o = rq_q.we;
      end
      default: ;
    endcase
  end

  assign zbt_addr_o = rq_q.adr[19:2];
  assign zbt_dat_o  = {2{rq_q.dat}};
  assign rd_half    = rq_q.adr[1] ? zbt_dat_i[31:16] : zbt_dat_i[15:0];

  // Idle cycles also count toward read-to-write turnaround.
  always_comb begin
    turn_d  = turn_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (!(|gnt) && turn_q != 2'd0) turn_d = turn_q - 2'd1;
      end
      TURN: turn_d = turn_q - 2'd1;
      DATA: turn_d = rq_q.we ? 2'd0 : TURN_LD;
      default: ;
    endcase
    if ((state_q inside {TURN, CMD, PIPE, DATA}) && !gcyc) abort_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rq_q      <= '0;
      prev_rd_q <= 1'b0;
      turn_q    <= 2'd0;
      abort_q   <= 1'b0;
      dat0_q    <= '0;
      dat1_q    <= '0;
    end else begin
      turn_q  <= turn_d;
      abort_q <= abort_d;
      if (state_q == IDLE && |gnt) rq_q <= req_sel;
      if (state_q == DATA) begin
        prev_rd_q <= ~rq_q.we;
        if (!rq_q.we) begin
          if (act_q) dat1_q <= rd_half;
          else       dat0_q <= rd_half;
        end
      end
    end
  end

endmodule

// File: doc/zbt_arbiter.md
Name: zbt_arbiter

Overview:
- Shares the board's pipelined ZBT SRAM (NoBL, 32-bit, 18-bit word address) between two 16-bit Wishbone masters: port 0 is the CPU, port 1 is the LCD/VGA fetch engine.
- Sequences the ZBT two-cycle pipeline (address, pipe, data), handles byte lanes and bus turnaround, and arbitrates between the ports.
- Sits between the Wishbone interconnect and the shared sram_flash pins.
- Flash chip enable is held inactive by the top level, not by this block.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins a simultaneous request.
- RD_TURN, 1: idle cycles inserted after a read before a write may start, for data-bus turnaround (0..3).

Ports:
- wb_clk_i  in  1  system clock; also drives sram_clk_ externally.
- wb_rst_i  in  1  synchronous active-high reset.
- wbN_adr_i  in  19  byte address [19:1], N = 0,1.
- wbN_dat_i  in  16  write data.
- wbN_dat_o  out  16  read data.
- wbN_sel_i  in  2  byte selects.
- wbN_we_i  in  1  write enable.
- wbN_cyc_i, wbN_stb_i  in  1  cycle and strobe.
- wbN_ack_o  out  1  acknowledge.
- zbt_addr_o  out  18  word address.
- zbt_dat_o  out  32  write data.
- zbt_dat_i  in  32  read data.
- zbt_dat_oe_o  out  1  tristate enable for the data bus.
- zbt_bw_n_o  out  4  byte writes, active low.
- zbt_we_n_o  out  1  write, active low.
- zbt_cen_n_o  out  1  chip enable (ce1b), active low.
- zbt_adv_ld_n_o  out  1  advance/load, active low.
- zbt_oe_n_o  out  1  output enable, active low.

Behaviour:
- Single clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values:
  - cen_n=1, we_n=1, oe_n=1, bw_n=4'hF, adv_ld_n=0, addr=0.
  - dat_oe=0, both ack=0, both dat_o=0.
  - FSM=IDLE; last_grant=1, so port 0 wins the first tie.
- Request: reqN = cycN & stbN & ~ackN.
- Arbitration happens only in IDLE.
  - Round-robin: on a tie, grant the port not granted last.
  - FIXED_PRIO=1: port 0 wins ties.
  - A single requester is always granted.
  - The grant and the request fields (adr, dat, sel, we) are latched at the transition out of IDLE.
- Address mapping:
  - zbt_addr = adr[19:2].
  - adr[1]=0 selects lanes [15:0], bw_n[1:0]; adr[1]=1 selects lanes [31:16], bw_n[3:2].
  - For a write, bw_n on the selected lane pair = ~sel; the other pair = 11. For a read, bw_n = 4'hF.
  - Write data is replicated onto both 16-bit halves.
- FSM states, one clock each:
  - IDLE: deselected (cen_n=1). On any req: if the previous access was a read, the new one is a write, and turn_cnt>0, go to TURN; otherwise go to CMD.
  - TURN: counts RD_TURN cycles since the last read's DATA, then goes to CMD.
  - CMD: cen_n=0, adv_ld_n=0, we_n=~we, addr and bw_n driven.
  - PIPE: cen_n=1 (deselect/NOP); for a read, oe_n=0.
  - DATA: write drives zbt_dat_o with dat_oe=1; read keeps oe_n=0 and registers zbt_dat_i at the end of the cycle (selected half -> dat_o).
  - ACK: granted ackN=1 for exactly one cycle; dat_oe=0, oe_n=1; next state IDLE.
- Latency: with no contention and no turnaround, ack is high in the 4th cycle after req is first seen in IDLE. Max throughput is one access per 5 cycles.
- Only one transaction is ever outstanding; the other port waits with ack=0.
- Abort: if the granted port drops cyc before ACK, the ZBT sequence still completes (no partial bus cycle), the ack is suppressed, and the FSM returns to IDLE.
- Reset mid-operation: next edge gives the reset values; dat_oe drops immediately; no ack is issued for the aborted access.
- dat_oN holds its last read value until the next read on that port.

Decomposition:
- Package zbt_arb_pkg:
  - state enum (IDLE, TURN, CMD, PIPE, DATA, ACK);
  - ZBT_AW=18, ZBT_DW=32, WB_DW=16;
  - inactive-level constants for the ZBT controls.
- Sub-module arb2_rr: two-requester round-robin/fixed arbiter.
  - Inputs: req[1:0], update strobe, FIXED_PRIO.
  - Outputs: one-hot grant, plus the last_grant register.
- The FSM and datapath stay in zbt_arbiter.

Test Plan:
- Port 0 read, adr=0x00006 (word 1, upper half), ZBT preloaded word1=0xBEEF1234 -> zbt_addr=1; oe_n low in PIPE and DATA; wb0_ack high in cycle 4; wb0_dat_o=0xBEEF.
- Port 1 write, adr=0x00010, dat=0xA55A, sel=2'b01 -> bw_n=4'b1110 in CMD; dat_oe high only in DATA; readback of word 4 gives 0x??5A with the other lanes unchanged.
- Simultaneous continuous reqs from both ports, FIXED_PRIO=0 -> grant sequence 0,1,0,1; each port acked every 10 cycles. With FIXED_PRIO=1 -> port 1 is acked only after port 0 drops stb.
- Read followed by write, RD_TURN=2 -> exactly 2 TURN cycles between the read's ACK/IDLE and the write's CMD; dat_oe never overlaps oe_n=0.
- Port 0 drops cyc during PIPE -> PIPE and DATA still complete, wb0_ack stays 0, FSM back in IDLE, and a pending port 1 request is granted next.
- wb_rst_i asserted during DATA of a write -> next edge: dat_oe=0, cen_n=1, bw_n=F, no ack; after reset release a port 0 tie wins first.
